// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM-stage controller and memory.
// master: the access unit (drives the request); slave: the memory model.
interface mem_access_unit_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller. Non-memory ops pass straight through to
// MEM_WB; loads/stores go out on a req/ready bus while the pipeline is stalled.
// Optional macro MEM_TIMEOUT_EN adds a REQ watchdog and a `timeout` pulse port.
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  mem_access_unit_if.master mem,
  input  logic        validIN,
  input  logic        MemReadIN,
  input  logic        MemWriteIN,
  input  logic [1:0]  SizeIN,
  input  logic        SignedIN,
  input  logic [31:0] ALU_IN,
  input  logic [31:0] StoreDataIN,
  input  logic [4:0]  DestinoIN,
  input  logic        MemtoRegIN,
  input  logic        RegWriteIN,
  input  logic        finIN,
  output logic        stall,
  output logic        misaligned,
  output logic [31:0] dataOUT,
  output logic [31:0] ALU_OUT,
  output logic [4:0]  DestinoOUT,
  output logic        MemtoRegOUT,
  output logic        RegWriteOUT,
`ifdef MEM_TIMEOUT_EN
  output logic        timeout,
`endif
  output logic        finOUT
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state;

  logic [31:0]       dataReg, capAlu;
  logic [4:0]        capDest;
  logic [1:0]        capSize;
  logic              capSigned, capLoad, capMemtoReg, capRegWrite, capFin;
  logic              access, aligned;
  logic [ADDR_W-1:0] addrFull;
  logic [3:0]        beNext;
  logic [31:0]       wdataNext;

`ifdef MEM_TIMEOUT_EN
  localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (CLOG < 8) ? 8 : ((CLOG > 32) ? 32 : CLOG);
  logic [CNT_W-1:0] cnt;
`endif

  assign access   = validIN & (MemReadIN | MemWriteIN);
  assign addrFull = ADDR_W'(ALU_IN);

  // Size 11 is reserved and behaves as a word access.
  function automatic logic [31:0] loadExt(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Alignment check plus byte-enable / lane-shifted store data for the access
  always_comb begin
    aligned   = 1'b1;
    beNext    = 4'b1111;
    wdataNext = StoreDataIN;
    case (SizeIN)
      2'b00: begin
        beNext    = 4'b0001 << ALU_IN[1:0];
        wdataNext = {24'h0, StoreDataIN[7:0]} << {ALU_IN[1:0], 3'b000};
      end
      2'b01: begin
        aligned   = ~ALU_IN[0];
        beNext    = ALU_IN[1] ? 4'b1100 : 4'b0011;
        wdataNext = ALU_IN[1] ? {StoreDataIN[15:0], 16'h0} : {16'h0, StoreDataIN[15:0]};
      end
      default: aligned = (ALU_IN[1:0] == 2'b00);
    endcase
  end

  // Request FSM: captures the instruction, owns the memory bus, holds load data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
      dataReg       <= '0;
      capAlu        <= '0;
      capDest       <= '0;
      capSize       <= '0;
      capSigned     <= 1'b0;
      capLoad       <= 1'b0;
      capMemtoReg   <= 1'b0;
      capRegWrite   <= 1'b0;
      capFin        <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt           <= '0;
      timeout       <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: if (access && aligned) begin
          mem.mem_req   <= 1'b1;
          mem.mem_we    <= MemWriteIN;
          mem.mem_addr  <= {addrFull[ADDR_W-1:2], 2'b00};
          mem.mem_be    <= beNext;
          mem.mem_wdata <= wdataNext;
          dataReg       <= '0;
          capAlu        <= ALU_IN;
          capDest       <= DestinoIN;
          capSize       <= SizeIN;
          capSigned     <= SignedIN;
          capLoad       <= MemReadIN & ~MemWriteIN;
          capMemtoReg   <= MemtoRegIN;
          capRegWrite   <= RegWriteIN;
          capFin        <= finIN;
`ifdef MEM_TIMEOUT_EN
          cnt           <= '0;
`endif
          state         <= REQ;
        end
        REQ: if (mem.mem_ready) begin
          mem.mem_req <= 1'b0;
          dataReg     <= capLoad ? loadExt(mem.mem_rdata, capAlu[1:0], capSize, capSigned) : 32'h0;
          state       <= RESP;
        end
`ifdef MEM_TIMEOUT_EN
        // cnt counts completed waiting cycles; this cycle makes it TIMEOUT_CYCLES
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem.mem_req <= 1'b0;
          capRegWrite <= 1'b0;
          dataReg     <= '0;
          timeout     <= 1'b1;
          state       <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
`endif
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // MEM_WB-facing outputs: passthrough in IDLE, bubble in REQ, captured op in RESP
  always_comb begin
    dataOUT     = '0;
    ALU_OUT     = ALU_IN;
    DestinoOUT  = DestinoIN;
    MemtoRegOUT = 1'b0;
    RegWriteOUT = 1'b0;
    finOUT      = 1'b0;
    stall       = 1'b0;
    misaligned  = 1'b0;
    if (!reset_n) begin
      ALU_OUT    = '0;
      DestinoOUT = '0;
    end else begin
      case (state)
        IDLE: if (validIN) begin
          if (!access) begin
            MemtoRegOUT = MemtoRegIN;
            RegWriteOUT = RegWriteIN;
            finOUT      = finIN;
          end else if (!aligned) begin
            misaligned = 1'b1;
            finOUT     = finIN;
          end else begin
            stall = 1'b1;
          end
        end
        REQ: begin
          stall      = 1'b1;
          ALU_OUT    = capAlu;
          DestinoOUT = capDest;
        end
        RESP: begin
          dataOUT     = dataReg;
          ALU_OUT     = capAlu;
          DestinoOUT  = capDest;
          MemtoRegOUT = capMemtoReg;
          RegWriteOUT = capRegWrite;
          finOUT      = capFin;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; expected MEM_WB results are queued when
// an instruction is driven and popped when the unit presents its result.
module tb_mem_access_unit;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 0, reset_n = 0;
  logic        validIN, MemReadIN, MemWriteIN, SignedIN, MemtoRegIN, RegWriteIN, finIN;
  logic [1:0]  SizeIN;
  logic [31:0] ALU_IN, StoreDataIN, dataOUT, ALU_OUT;
  logic [4:0]  DestinoIN, DestinoOUT;
  logic        stall, misaligned, MemtoRegOUT, RegWriteOUT, finOUT;
`ifdef MEM_TIMEOUT_EN
  logic        timeout;
`endif

  mem_access_unit_if #(.ADDR_W(32)) mif ();

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .mem(mif.master),
    .validIN(validIN), .MemReadIN(MemReadIN), .MemWriteIN(MemWriteIN), .SizeIN(SizeIN),
    .SignedIN(SignedIN), .ALU_IN(ALU_IN), .StoreDataIN(StoreDataIN), .DestinoIN(DestinoIN),
    .MemtoRegIN(MemtoRegIN), .RegWriteIN(RegWriteIN), .finIN(finIN),
    .stall(stall), .misaligned(misaligned), .dataOUT(dataOUT), .ALU_OUT(ALU_OUT),
    .DestinoOUT(DestinoOUT), .MemtoRegOUT(MemtoRegOUT), .RegWriteOUT(RegWriteOUT),
`ifdef MEM_TIMEOUT_EN
    .timeout(timeout),
`endif
    .finOUT(finOUT)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] alu;
    logic [4:0]  dst;
    logic        m2r, rw, fin;
  } exp_t;
  exp_t sb[$];

  int nTests = 0, nFail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic popCheck(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      nTests++; nFail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, dataOUT, e.data);
      chk({tag, "_alu"},  ALU_OUT, e.alu);
      chk({tag, "_dst"},  32'(DestinoOUT), 32'(e.dst));
      chk({tag, "_ctl"},  {29'h0, MemtoRegOUT, RegWriteOUT, finOUT}, {29'h0, e.m2r, e.rw, e.fin});
    end
  endtask

  task automatic drive(input logic v, rd, wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] alu, sd, input logic [4:0] dst,
                       input logic m2r, rw, fin);
    validIN = v; MemReadIN = rd; MemWriteIN = wr; SizeIN = sz; SignedIN = sgn;
    ALU_IN = alu; StoreDataIN = sd; DestinoIN = dst; MemtoRegIN = m2r; RegWriteIN = rw; finIN = fin;
  endtask

  // One aligned memory op: memory answers after `waits` extra REQ cycles.
  task automatic memOp(input string tag, input logic rd, wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] alu, sd, input logic [4:0] dst, input logic m2r, rw,
                       input int waits, input logic [31:0] rdata,
                       input logic [31:0] eAddr, input logic [3:0] eBe, input logic [31:0] eWd,
                       input logic [31:0] eData);
    int reqN = 0, stallCnt = 1;
    bit done = 0;
    @(posedge clk); #1;
    drive(1, rd, wr, sz, sgn, alu, sd, dst, m2r, rw, 1);
    sb.push_back('{data: eData, alu: alu, dst: dst, m2r: m2r, rw: rw, fin: 1'b1});
    #4 chk({tag, "_stall0"}, 32'(stall), 32'd1);
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clk); #1;
      mif.mem_ready = 0;
      if (mif.mem_req) begin
        if (reqN == 0) begin
          chk({tag, "_addr"}, mif.mem_addr, eAddr);
          chk({tag, "_be"},   32'(mif.mem_be), 32'(eBe));
          chk({tag, "_we"},   32'(mif.mem_we), 32'(wr));
          if (wr) chk({tag, "_wdata"}, mif.mem_wdata, eWd);
        end
        if (reqN == waits) begin mif.mem_ready = 1; mif.mem_rdata = rdata; end
        reqN++;
      end else if (reqN == 0) chk({tag, "_req"}, 32'(mif.mem_req), 32'd1);
      #4;
      if (!stall) done = 1; else stallCnt++;
    end
    if (!done) begin nTests++; nFail++; $error("FAIL %s: stall never released", tag); end
    chk({tag, "_stallcyc"}, 32'(stallCnt), 32'(waits + 2));
    chk({tag, "_reqdrop"}, 32'(mif.mem_req), 32'd0);
    popCheck(tag);
    validIN = 0;
    mif.mem_ready = 0;
  endtask

  initial begin
    mif.mem_ready = 0; mif.mem_rdata = 0;
    drive(1, 0, 0, 2'b10, 0, 32'hDEAD_0000, 0, 5'd9, 1, 1, 1);
    #12;
    // reset state (inputs live, outputs must still be quiet)
    chk("rst_req",   32'(mif.mem_req), 0);
    chk("rst_addr",  mif.mem_addr, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_ctl",   {29'h0, MemtoRegOUT, RegWriteOUT, finOUT}, 0);
    chk("rst_alu",   ALU_OUT, 0);
    @(posedge clk); #1 reset_n = 1;

    // ADD passthrough, with a stray mem_ready that must be ignored
    @(posedge clk); #1;
    drive(1, 0, 0, 2'b10, 0, 32'h1234, 0, 5'd5, 0, 1, 0);
    mif.mem_ready = 1;
    sb.push_back('{data: 0, alu: 32'h1234, dst: 5'd5, m2r: 0, rw: 1, fin: 0});
    #4 chk("add_stall", 32'(stall), 0);
    popCheck("add");
    @(posedge clk); #1 mif.mem_ready = 0;
    #4 chk("stray_ready_req", 32'(mif.mem_req), 0);

    // validIN=0 bubble
    drive(0, 1, 0, 2'b10, 0, 32'h40, 0, 5'd3, 1, 1, 1);
    @(posedge clk); #1;
    sb.push_back('{data: 0, alu: 32'h40, dst: 5'd3, m2r: 0, rw: 0, fin: 0});
    #4 chk("bubble_stall", 32'(stall), 0);
    popCheck("bubble");

    memOp("lw",  1, 0, 2'b10, 0, 32'h100, 0, 5'd7, 1, 1, 2, 32'hCAFEBABE,
          32'h100, 4'b1111, 0, 32'hCAFEBABE);
    memOp("lbs", 1, 0, 2'b00, 1, 32'h103, 0, 5'd8, 1, 1, 0, 32'h80123456,
          32'h100, 4'b1000, 0, 32'hFFFFFF80);
    memOp("lbu", 1, 0, 2'b00, 0, 32'h103, 0, 5'd8, 1, 1, 1, 32'h80123456,
          32'h100, 4'b1000, 0, 32'h00000080);
    memOp("lhs", 1, 0, 2'b01, 1, 32'h302, 0, 5'd4, 1, 1, 0, 32'h9ABC1234,
          32'h300, 4'b1100, 0, 32'hFFFF9ABC);
    memOp("sh",  0, 1, 2'b01, 0, 32'h202, 32'h1234BEEF, 5'd0, 0, 0, 1, 32'hFFFFFFFF,
          32'h200, 4'b1100, 32'hBEEF0000, 0);
    memOp("sb",  0, 1, 2'b00, 0, 32'h401, 32'h000000A5, 5'd0, 0, 0, 0, 0,
          32'h400, 4'b0010, 32'h0000A500, 0);

    // misaligned word load and half load
    @(posedge clk); #1;
    drive(1, 1, 0, 2'b10, 0, 32'h101, 0, 5'd6, 1, 1, 1);
    sb.push_back('{data: 0, alu: 32'h101, dst: 5'd6, m2r: 0, rw: 0, fin: 1});
    #4 chk("mis_pulse", 32'(misaligned), 1);
    chk("mis_stall", 32'(stall), 0);
    popCheck("mis");
    @(posedge clk); #1 SizeIN = 2'b01; ALU_IN = 32'h203;
    #4 chk("mish_pulse", 32'(misaligned), 1);
    validIN = 0;
    @(posedge clk); #1;
    #4 chk("mis_noreq", 32'(mif.mem_req), 0);
    chk("mis_fall", 32'(misaligned), 0);

    // reset in the middle of REQ
    @(posedge clk); #1;
    drive(1, 1, 0, 2'b10, 0, 32'h500, 0, 5'd2, 1, 1, 1);
    @(posedge clk); #1 chk("rreq_req", 32'(mif.mem_req), 1);
    #2 reset_n = 0;
    #1 chk("rreq_drop", 32'(mif.mem_req), 0);
    chk("rreq_rw", 32'(RegWriteOUT), 0);
    chk("rreq_stall", 32'(stall), 0);
    validIN = 0;
    @(posedge clk); #1 reset_n = 1;
    #4 chk("rreq_idle", {30'h0, mif.mem_req, stall}, 0);
    chk("rreq_nowb", 32'(RegWriteOUT), 0);

`ifdef MEM_TIMEOUT_EN
    begin
      int sc = 1;
      bit rel = 0;
      @(posedge clk); #1;
      drive(1, 1, 0, 2'b10, 0, 32'h600, 0, 5'd1, 1, 1, 1);
      #4;
      for (int n = 0; n < 40 && !rel; n++) begin
        @(posedge clk); #5;
        if (!stall) rel = 1; else sc++;
      end
      validIN = 0;
      chk("to_stallcyc", 32'(sc), 32'(TO + 1));
      chk("to_pulse", 32'(timeout), 1);
      chk("to_rw", 32'(RegWriteOUT), 0);
      chk("to_req", 32'(mif.mem_req), 0);
      @(posedge clk); #5 chk("to_fall", 32'(timeout), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
